microsequencer: RTL
===================

# microsequencer

Next-state sequencer for the microprogrammed multicycle RISC-V control unit. It holds the current micro-address and drives the 4-bit address of the microcode ROM. From the ROM's 3-bit sequencing field (control word bits [2:0]) and the instruction opcode, it selects the next micro-address: increment, opcode dispatch, fetch or ALU write-back. It also reports instruction completion and illegal-opcode/sequence events.

## Interface
Parameters:
- `NUM_STATES`, 11, number of populated ROM words (valid micro-addresses 0..NUM_STATES-1).

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  advance enable; when low, every register holds.
- `opcode`  in  7  instr[6:0] from the instruction register, stable from S1 onward.
- `seq`  in  3  sequencing field of the current ROM word (ROM out[2:0]).
- `addr`  out  4  current micro-address, registered, to the ROM address input.
- `instr_done`  out  1  registered one-cycle pulse in the first cycle of S0 after an instruction completes.
- `illegal`  out  1  registered one-cycle pulse in the first cycle of S0 after an illegal redirect.

## Operation
- States (micro-addresses): S0 Fetch=0, S1 Decode=1, S2 MemAdr=2, S3 MemRead=3, S4 MemWB=4, S5 MemWrite=5, S6 ExecuteR=6, S7 ALUWB=7, S8 ExecuteI=8, S9 JAL=9, S10 BEQ=10.
- `seq` codes:
  - 000 INCR: next = addr+1.
  - 001 DISP1: opcode dispatch.
  - 010 DISP2: memory dispatch.
  - 011 FETCH: next = S0.
  - 100 ALUWB: next = S7.
  - 101–111: reserved.
- DISP1:
  - 0000011 lw → S2.
  - 0100011 sw → S2.
  - 0110011 R-type → S6.
  - 0010011 I-type ALU → S8.
  - 1101111 jal → S9.
  - 1100011 beq → S10.
  - Any other opcode → S0 with illegal.
- DISP2:
  - 0000011 → S3.
  - 0100011 → S5.
  - Any other opcode → S0 with illegal.
- Illegal redirect (next = S0, illegal event) also occurs for:
  - Reserved `seq` code.
  - INCR when addr+1 ≥ NUM_STATES.
  - Any current addr ≥ NUM_STATES, regardless of `seq`.
- `instr_done` is set next cycle when FETCH is taken legally; S0 INCR does not set it.
- `illegal` and `instr_done` are mutually exclusive.

## Timing
- Reset (when `reset`=1 at a clock edge): addr=0, instr_done=0, illegal=0. Reset overrides `en`.
- The ROM is combinational, so `seq` reflects `addr` in the same cycle. The next address is computed combinationally and registered at the next edge: one micro-step per enabled cycle.
- `en`=0:
  - addr holds.
  - instr_done and illegal are cleared to 0; pulses are never stretched.
  - On the next `en`=1 cycle, evaluation resumes from the held addr.
- Cycle counts from entering S0 to the next S0, with `en` held high:
  - lw: 5 (S0 S1 S2 S3 S4).
  - sw: 4.
  - R-type: 4.
  - I-type: 4.
  - jal: 4.
  - beq: 3.
- `opcode` is sampled only in S1 and S2. Changes in other states have no effect.
- Reset asserted mid-instruction: addr=0 at that edge, no pulse is generated, and execution restarts at Fetch.

## Structure
- Shared package `microcode_pkg`:
  - `seq_t` enum of the 3-bit sequencing codes.
  - `ustate_t` enum for S0..S10 (4-bit).
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ.
  - The ROM's seq-field bit range.
- One sub-module `useq_dispatch`:
  - Combinational.
  - Inputs: `seq`, `opcode`, `addr`.
  - Outputs: next address and illegal flag.
- The top level holds the `addr` register and both pulse registers.

## Test plan
- Reset held 2 cycles, then lw (opcode 0000011) with ROM attached, en=1 → addr sequence 0,1,2,3,4,0; instr_done=1 only in the final S0 cycle; illegal=0 throughout.
- beq (1100011) followed by R-type (0110011) → 0,1,10,0,1,6,7,0; instr_done pulses twice, each exactly 1 cycle.
- Opcode 1111111 at S1 → next addr=0, illegal=1 for one cycle, instr_done=0; same result for opcode 0110011 presented with seq=010.
- Forced seq=110 at addr=4 → next addr=0 with illegal pulse; forced INCR at addr=10 → addr=0 with illegal pulse.
- sw with en=0 for 3 cycles while at S2 → addr stays 2 and both pulses stay 0; after en=1 the sequence continues 5,0 with instr_done=1.
- reset=1 while at addr=6, with en=0 at the same time → addr=0, both pulses 0 next cycle; the following fetch proceeds normally.

Source files
------------

// File: rtl/microcode_pkg.sv
// Shared definitions for the microprogrammed RISC-V control unit:
// sequencing codes, micro-state numbering and the opcodes it dispatches on.
package microcode_pkg;

  typedef enum logic [2:0] {
    SEQ_INCR  = 3'b000,
    SEQ_DISP1 = 3'b001,
    SEQ_DISP2 = 3'b010,
    SEQ_FETCH = 3'b011,
    SEQ_ALUWB = 3'b100
  } seq_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } ustate_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Position of the sequencing field inside a ROM control word.
  localparam int SEQ_LSB = 0;
  localparam int SEQ_MSB = 2;

endpackage

// File: rtl/useq_dispatch.sv
// Combinational next-micro-address selection. Anything that would leave the
// populated ROM range, or any unknown sequencing/opcode combination, falls
// back to Fetch and raises the illegal flag.
module useq_dispatch
  import microcode_pkg::*;
#(
  parameter int NUM_STATES = 11
) (
  input  logic [2:0] seq,
  input  logic [6:0] opcode,
  input  logic [3:0] addr,
  output logic [3:0] nxt,
  output logic       ill
);

  // 5-bit compare so addr+1 from 15 cannot wrap back into the legal range.
  localparam logic [4:0] LIMIT = 5'(NUM_STATES);

  logic [4:0] incr;
  assign incr = {1'b0, addr} + 5'd1;

  // Select the next micro-address from the sequencing code and opcode.
  always_comb begin
    nxt = S_FETCH;
    ill = 1'b0;
    if ({1'b0, addr} >= LIMIT) begin
      ill = 1'b1;
    end else begin
      case (seq)
        SEQ_INCR: begin
          if (incr >= LIMIT) ill = 1'b1;
          else               nxt = incr[3:0];
        end
        SEQ_DISP1: begin
          case (opcode)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_R:         nxt = S_EXECR;
            OP_I:         nxt = S_EXECI;
            OP_JAL:       nxt = S_JAL;
            OP_BEQ:       nxt = S_BEQ;
            default:      ill = 1'b1;
          endcase
        end
        SEQ_DISP2: begin
          case (opcode)
            OP_LW:   nxt = S_MEMREAD;
            OP_SW:   nxt = S_MEMWRITE;
            default: ill = 1'b1;
          endcase
        end
        SEQ_FETCH: nxt = S_FETCH;
        SEQ_ALUWB: nxt = S_ALUWB;
        default:   ill = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Micro-address register for the multicycle control unit, plus the
// instruction-complete and illegal-event pulses reported on entry to Fetch.
module microsequencer
  import microcode_pkg::*;
#(
  parameter int NUM_STATES = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] opcode,
  input  logic [2:0] seq,
  output logic [3:0] addr,
  output logic       instr_done,
  output logic       illegal
);

  logic [3:0] nxt_addr;
  logic       nxt_ill;
  logic       fetch_ok;

  useq_dispatch #(
    .NUM_STATES(NUM_STATES)
  ) u_dispatch (
    .seq    (seq),
    .opcode (opcode),
    .addr   (addr),
    .nxt    (nxt_addr),
    .ill    (nxt_ill)
  );

  // Only a legally taken FETCH completes an instruction; an illegal redirect
  // also lands in Fetch but must not count as completion.
  assign fetch_ok = (seq == SEQ_FETCH) && !nxt_ill;

  // Advance one micro-step per enabled cycle; pulses drop whenever stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= S_FETCH;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end else if (en) begin
      addr       <= nxt_addr;
      instr_done <= fetch_ok;
      illegal    <= nxt_ill;
    end else begin
      instr_done <= 1'b0;
      illegal    <= 1'b0;
    end
  end

endmodule
